seg_scan: RTL
=============

# seg_scan

Multiplexed six-digit seven-segment display driver for the clock/alarm datapath. It consumes the BCD digit pairs produced by the hour, minute and second counters and scans them onto a common segment bus with one-hot digit enables. It sits between the counter/adjust logic and the board's display pins. When the user is adjusting a field, it blinks the two digits of that field.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each digit is shown; must be ≥ 4.
- `BLINK_DIV`, default 12500000: clock cycles per blink half-period; only used with blink compiled in.
- `SEG_ACTIVE_LOW`, default 1: 1 means segment and select outputs drive 0 = lit/enabled; 0 means active-high.
- `clk` input, 1 bit: single system clock, rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `hour_h`, `hour_l`, `min_h`, `min_l`, `sec_h`, `sec_l` inputs, 4 bits each: BCD digits from the counters.
- `sw17` input, 1 bit: adjust-mode switch; 1 means the user is adjusting.
- `adjust` input, 2 bits: field under adjustment. 0 = hours, 1 = minutes, 2 = seconds, 3 = none.
- `seg` output, 8 bits: bit 0 = a … bit 6 = g, bit 7 = dp.
- `sel` output, 6 bits: digit enables. `sel[0]` = `sec_l` (rightmost) … `sel[5]` = `hour_h`.

## Operation
- **Prescaler `pcnt`**: counts 0 to SCAN_DIV-1, then wraps. `scan_end` is asserted when `pcnt` = SCAN_DIV-1.
- **Scan index `idx`**:
  - Range 0 to 5; advances on `scan_end`.
  - Wraps 5 → 0.
  - Digit order by `idx`: 0 `sec_l`, 1 `sec_h`, 2 `min_l`, 3 `min_h`, 4 `hour_l`, 5 `hour_h`.
- **Snapshot register**:
  - 24 bits, holding all six inputs.
  - Loaded on `scan_end` when `idx` = 5, i.e. at each frame boundary.
  - Every frame therefore shows one coherent time, even if the counters roll over mid-frame.
- **Decode**:
  - BCD 0–9 maps to standard glyphs.
  - Codes 10–15 are shown blank (all segments off).
- **Decimal point**: lit on `idx` 2 and 4, acting as the hh.mm.ss separators. Off elsewhere.
- **Anti-ghosting**: in the cycle where `pcnt` = 0, `sel` is all-inactive. Segments still change in that same cycle.
- **Output polarity**: all outputs are inverted when SEG_ACTIVE_LOW = 1.
- **Reset state**:
  - `pcnt` = 0, `idx` = 0, snapshot = 0, blink phase = 1 (visible).
  - `seg` = all inactive, `sel` = all inactive.
- **Mid-operation reset**: output goes inactive immediately (asynchronously). Scanning restarts at `idx` 0, showing the zero snapshot until the first frame boundary.

## Timing
- `seg` and `sel` are registered and reflect `idx`/`pcnt` with 1-cycle latency.
- Per digit slot of SCAN_DIV cycles:
  - Cycle 0: `sel` inactive, `seg` = new glyph.
  - Cycles 1 to SCAN_DIV-1: `sel` one-hot on `idx`.
- Frame period is 6·SCAN_DIV cycles.
- New input values appear on the display after at most 6·SCAN_DIV + 1 cycles. The value at the frame-boundary edge is captured and shown from the next `idx` 0 slot.
- `sw17`/`adjust` are sampled every cycle, with no snapshot. Blanking takes effect on the next registered output.
- When `scan_end` and the blink toggle coincide, both updates apply in the same cycle. Neither has priority.

## Configuration
- **`SEG_BLINK_EN` defined**:
  - Blink counter runs 0 to BLINK_DIV-1 and toggles `phase` at wrap.
  - While `sw17` = 1, `adjust` ≠ 3 and `phase` = 0, both digits of the selected field show blank segments, including dp.
  - `sel` is unaffected.
- **`SEG_BLINK_EN` undefined**:
  - No blink counter or phase register exists.
  - `sw17` and `adjust` stay as ports but are ignored.
  - All digits are always shown.

## Structure
- Shared package `seg_pkg`:
  - Field codes `FIELD_HOUR` = 0, `FIELD_MIN` = 1, `FIELD_SEC` = 2, `FIELD_NONE` = 3.
  - Glyph constants for 0–9 and blank (active-high form).
  - Digit-index constants.
- Sub-module `bcd7seg`: combinational 4-bit BCD to 7-bit glyph, blank for codes above 9. It is instantiated once, on the muxed snapshot digit.

## Test plan
All scenarios use SCAN_DIV = 4, BLINK_DIV = 16, SEG_ACTIVE_LOW = 0.

- **Reset**: hold `rst` for 3 cycles. Required: `sel` = 0 and `seg` = 0 throughout. After release, first slot shows `sel` = 000001 from cycle 2 and `seg` = 0x3F (glyph "0").
- **Frame scan**: inputs 12:34:56. After one frame boundary, the slots show, in order:
  - `sel` 000001 with `seg` 0x7D ("6")
  - `sel` 000010 with 0x6D ("5")
  - `sel` 000100 with 0xE6 ("4" + dp)
  - `sel` 001000 with 0x4F ("3")
  - `sel` 010000 with 0xDB ("2" + dp)
  - `sel` 100000 with 0x06 ("1")
- **Coherence**: change `sec_l` from 9 to 0 mid-frame. Required: the new value appears only after the next `idx` 5 → 0 wrap, never within the current frame.
- **Invalid code**: `min_l` = 4'hC. Required: `idx` 2 slot shows `seg` = 0x80 (dp only).
- **Blink**: with `SEG_BLINK_EN` defined, set `sw17` = 1, `adjust` = 1. Required: digits 2–3 show `seg` = 0 for 16 cycles, then glyphs for 16 cycles, alternating. Set `adjust` = 3: no blanking.
- **Reset mid-frame**: assert `rst` at `idx` 3. Required: outputs go inactive in the same cycle. After release, scanning resumes at `idx` 0 with zero glyphs.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the six-digit display scanner: field codes,
// active-high glyph constants, digit-slot indices and the snapshot layout.
package seg_pkg;

  // Field codes carried on the adjust input
  typedef enum logic [1:0] {
    FIELD_HOUR = 2'd0,
    FIELD_MIN  = 2'd1,
    FIELD_SEC  = 2'd2,
    FIELD_NONE = 2'd3
  } field_t;

  // Active-high glyphs, bit 0 = a ... bit 6 = g
  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h6F;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  // Scan slot for each digit, rightmost first
  localparam logic [2:0] DIG_SEC_L  = 3'd0;
  localparam logic [2:0] DIG_SEC_H  = 3'd1;
  localparam logic [2:0] DIG_MIN_L  = 3'd2;
  localparam logic [2:0] DIG_MIN_H  = 3'd3;
  localparam logic [2:0] DIG_HOUR_L = 3'd4;
  localparam logic [2:0] DIG_HOUR_H = 3'd5;
  localparam int         NUM_DIGITS = 6;

  // One coherent copy of all six counter digits
  typedef struct packed {
    logic [3:0] hour_h;
    logic [3:0] hour_l;
    logic [3:0] min_h;
    logic [3:0] min_l;
    logic [3:0] sec_h;
    logic [3:0] sec_l;
  } snap_t;

  // Which clock field a scan slot belongs to
  function automatic field_t field_of_digit(input logic [2:0] dig);
    field_t f;
    case (dig)
      DIG_SEC_L, DIG_SEC_H:   f = FIELD_SEC;
      DIG_MIN_L, DIG_MIN_H:   f = FIELD_MIN;
      DIG_HOUR_L, DIG_HOUR_H: f = FIELD_HOUR;
      default:                f = FIELD_NONE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/bcd7seg.sv
// Combinational BCD to seven-segment decoder (active-high glyph).
// Codes 10..15 decode to a blank digit rather than hex letters.
module bcd7seg
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] glyph
);

  // Table lookup of the standard digit shapes
  always_comb begin
    glyph = GLYPH_BLANK;
    case (bcd)
      4'd0:    glyph = GLYPH_0;
      4'd1:    glyph = GLYPH_1;
      4'd2:    glyph = GLYPH_2;
      4'd3:    glyph = GLYPH_3;
      4'd4:    glyph = GLYPH_4;
      4'd5:    glyph = GLYPH_5;
      4'd6:    glyph = GLYPH_6;
      4'd7:    glyph = GLYPH_7;
      4'd8:    glyph = GLYPH_8;
      4'd9:    glyph = GLYPH_9;
      default: glyph = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan.sv
// Six-digit multiplexed seven-segment scanner for the clock/alarm display.
// Digits are captured once per frame so a frame never mixes two times.
// Optional field blinking during adjustment is compiled in with the
// macro SEG_BLINK_EN; without it sw17/adjust are accepted but ignored.
module seg_scan
  import seg_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int BLINK_DIV      = 12500000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] hour_h,
  input  logic [3:0] hour_l,
  input  logic [3:0] min_h,
  input  logic [3:0] min_l,
  input  logic [3:0] sec_h,
  input  logic [3:0] sec_l,
  input  logic       sw17,
  input  logic [1:0] adjust,
  output logic [7:0] seg,
  output logic [5:0] sel
);

  localparam int             PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]  PCNT_LAST = PW'(SCAN_DIV - 1);
  localparam logic [7:0]     SEG_OFF   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [5:0]     SEL_OFF   = SEG_ACTIVE_LOW ? 6'h3F : 6'h00;

  logic [PW-1:0] pcnt;
  logic          scan_end;
  logic [2:0]    idx;
  snap_t         snap;
  logic [3:0]    digit;
  logic [6:0]    glyph;
  logic          dp;
  logic          blank;
  logic [7:0]    seg_ah;
  logic [5:0]    sel_ah;

  assign scan_end = (pcnt == PCNT_LAST);

  // Prescaler: one digit slot every SCAN_DIV cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt <= '0;
    end else if (scan_end) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  // Scan index walks the six digits, rightmost first
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= DIG_SEC_L;
    end else if (scan_end) begin
      idx <= (idx == DIG_HOUR_H) ? DIG_SEC_L : idx + 3'd1;
    end
  end

  // Capture all digits together at the frame boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap <= '0;
    end else if (scan_end && (idx == DIG_HOUR_H)) begin
      snap <= {hour_h, hour_l, min_h, min_l, sec_h, sec_l};
    end
  end

  // Pick the snapshot digit for the current slot
  always_comb begin
    digit = 4'hF;
    case (idx)
      DIG_SEC_L:  digit = snap.sec_l;
      DIG_SEC_H:  digit = snap.sec_h;
      DIG_MIN_L:  digit = snap.min_l;
      DIG_MIN_H:  digit = snap.min_h;
      DIG_HOUR_L: digit = snap.hour_l;
      DIG_HOUR_H: digit = snap.hour_h;
      default:    digit = 4'hF;
    endcase
  end

  bcd7seg u_dec (
    .bcd   (digit),
    .glyph (glyph)
  );

  // Decimal points separate hh.mm.ss
  assign dp = (idx == DIG_MIN_L) || (idx == DIG_HOUR_L);

`ifdef SEG_BLINK_EN
  localparam int            BW        = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BW-1:0] BCNT_LAST = BW'(BLINK_DIV - 1);

  logic [BW-1:0] bcnt;
  logic          phase;

  // Blink timebase: phase flips every BLINK_DIV cycles, starting visible
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt  <= '0;
      phase <= 1'b1;
    end else if (bcnt == BCNT_LAST) begin
      bcnt  <= '0;
      phase <= ~phase;
    end else begin
      bcnt <= bcnt + 1'b1;
    end
  end

  assign blank = sw17 && (field_t'(adjust) != FIELD_NONE) && !phase &&
                 (field_of_digit(idx) == field_t'(adjust));
`else
  logic unused_adjust;

  assign unused_adjust = ^{sw17, adjust};
  assign blank         = 1'b0;
`endif

  assign seg_ah = blank ? 8'h00 : {dp, glyph};
  assign sel_ah = (pcnt == '0) ? 6'h00 : (6'b000001 << idx);

  // Registered pin drivers; slot start keeps all digits off to avoid ghosting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= SEG_OFF;
      sel <= SEL_OFF;
    end else begin
      seg <= SEG_ACTIVE_LOW ? ~seg_ah : seg_ah;
      sel <= SEG_ACTIVE_LOW ? ~sel_ah : sel_ah;
    end
  end

endmodule
